// File: rtl/led_pkg.sv
// Shared LED pattern definitions.
// Widths, reset constants and FSM state types for the LED stages.
package led_pkg;

    localparam int LED_W = 18;

    localparam logic [LED_W-1:0] RUN_INIT   = 18'h00001;
    localparam logic [LED_W-1:0] PP_INIT    = 18'h00001;
    localparam logic [LED_W-1:0] BAR_INIT   = 18'h00000;
    localparam logic [LED_W-1:0] BLINK_INIT = 18'h2AAAA;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } pp_dir_t;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } bar_phase_t;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [LED_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler for LED stages.
// Emits a one-cycle tick every TICK_DIV enabled clocks.
module led_tick_gen #(
    parameter int TICK_DIV = 6_250_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = enable && !clear && (cnt_q == CNT_MAX);

    // Next count: clear restarts, enable advances and wraps, else hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Four free-running LED patterns advancing on a shared step tick.
// Every output comes straight from a register.
module led_pattern_gen #(
    parameter int LED_W    = 18,
    parameter int TICK_DIV = 6_250_000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             clear,
    output logic             step,
    output logic [LED_W-1:0] ledmode1,
    output logic [LED_W-1:0] ledmode2,
    output logic [LED_W-1:0] ledmode3,
    output logic [LED_W-1:0] ledmode4
);

    import led_pkg::*;

    logic tick;

    logic             step_q,  step_d;
    logic [LED_W-1:0] run_q,   run_d;
    logic [LED_W-1:0] pp_q,    pp_d;
    pp_dir_t          dir_q,   dir_d;
    logic [LED_W-1:0] bar_q,   bar_d;
    bar_phase_t       phase_q, phase_d;
    logic [LED_W-1:0] blink_q, blink_d;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .clear   (clear),
        .tick    (tick)
    );

    // Next-state for all patterns; clear wins over tick.
    always_comb begin
        step_d  = 1'b0;
        run_d   = run_q;
        pp_d    = pp_q;
        dir_d   = dir_q;
        bar_d   = bar_q;
        phase_d = phase_q;
        blink_d = blink_q;
        if (clear) begin
            run_d   = RUN_INIT;
            pp_d    = PP_INIT;
            dir_d   = LEFT;
            bar_d   = BAR_INIT;
            phase_d = FILL;
            blink_d = BLINK_INIT;
        end else if (tick) begin
            step_d = 1'b1;
            if (is_onehot(run_q)) begin
                run_d = {run_q[LED_W-2:0], run_q[LED_W-1]};
            end else begin
                run_d = RUN_INIT;
            end
            if (!is_onehot(pp_q)) begin
                pp_d  = PP_INIT;
                dir_d = LEFT;
            end else begin
                unique case (dir_q)
                    LEFT: begin
                        if (pp_q[LED_W-1]) begin
                            dir_d = RIGHT;
                            pp_d  = pp_q >> 1;
                        end else begin
                            pp_d = pp_q << 1;
                        end
                    end
                    RIGHT: begin
                        if (pp_q[0]) begin
                            dir_d = LEFT;
                            pp_d  = pp_q << 1;
                        end else begin
                            pp_d = pp_q >> 1;
                        end
                    end
                endcase
            end
            unique case (phase_q)
                FILL: begin
                    if (&bar_q) begin
                        phase_d = DRAIN;
                        bar_d   = {bar_q[LED_W-2:0], 1'b0};
                    end else begin
                        bar_d = {bar_q[LED_W-2:0], 1'b1};
                    end
                end
                DRAIN: begin
                    if (bar_q == '0) begin
                        phase_d = FILL;
                        bar_d   = LED_W'(1);
                    end else begin
                        bar_d = {bar_q[LED_W-2:0], 1'b0};
                    end
                end
            endcase
            blink_d = ~blink_q;
        end
    end

    // Pattern and step registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_q  <= 1'b0;
            run_q   <= RUN_INIT;
            pp_q    <= PP_INIT;
            dir_q   <= LEFT;
            bar_q   <= BAR_INIT;
            phase_q <= FILL;
            blink_q <= BLINK_INIT;
        end else begin
            step_q  <= step_d;
            run_q   <= run_d;
            pp_q    <= pp_d;
            dir_q   <= dir_d;
            bar_q   <= bar_d;
            phase_q <= phase_d;
            blink_q <= blink_d;
        end
    end

    assign step     = step_q;
    assign ledmode1 = run_q;
    assign ledmode2 = pp_q;
    assign ledmode3 = bar_q;
    assign ledmode4 = blink_q;

endmodule
